// File: rtl/min_key_scheduler_pkg.sv
// Shared types and default sizing for the minimum-key scheduler.
package min_sched_pkg;

  // Scan controller states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int KEY_W_DEF = 6;
  localparam int N_REQ_DEF = 8;

endpackage

// File: rtl/min_key_scheduler_if.sv
// Request/result bundle between the request collector, the scheduler and the dispatch stage.
interface min_key_scheduler_if
  import min_sched_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int KEY_W = KEY_W_DEF
) ();

  localparam int IDX_W = $clog2(N_REQ);

  logic                   i_start;
  logic                   i_abort;
  logic [N_REQ*KEY_W-1:0] i_keys;
  logic [N_REQ-1:0]       i_req_mask;

  logic                   o_busy;
  logic                   o_done;
  logic                   o_valid;
  logic                   o_none;
  logic [IDX_W-1:0]       o_min_idx;
  logic [KEY_W-1:0]       o_min_key;

  // Requester side: launches scans and consumes the result
  modport master (
    output i_start, i_abort, i_keys, i_req_mask,
    input  o_busy, o_done, o_valid, o_none, o_min_idx, o_min_key
  );

  // Scheduler side
  modport slave (
    input  i_start, i_abort, i_keys, i_req_mask,
    output o_busy, o_done, o_valid, o_none, o_min_idx, o_min_key
  );

endinterface

// File: rtl/min_key_scheduler_key_lt_cmp.sv
// Unsigned strict less-than comparator, shared by the scan loop.
module key_lt_cmp #(
  parameter int KEY_W = 6
) (
  input  logic [KEY_W-1:0] a,
  input  logic [KEY_W-1:0] b,
  output logic             a_lt_b
);

  // Walk from the MSB; the first differing bit decides the ordering
  always_comb begin
    logic found;
    a_lt_b = 1'b0;
    found  = 1'b0;
    for (int i = KEY_W - 1; i >= 0; i--) begin
      if (!found && (a[i] != b[i])) begin
        a_lt_b = b[i];
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/min_key_scheduler.sv
// Sequential minimum-key scheduler: one shared comparator visits one requester per cycle.
module min_key_scheduler
  import min_sched_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int KEY_W = KEY_W_DEF
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  min_key_scheduler_if.slave   bus
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);

  state_e           state;

  logic [KEY_W-1:0] snap_keys [N_REQ];
  logic [N_REQ-1:0] snap_mask;

  logic [IDX_W-1:0] idx;
  logic             seeded;
  logic [KEY_W-1:0] best_key;
  logic [IDX_W-1:0] best_idx;

  logic             busy_q;
  logic             done_q;
  logic             valid_q;
  logic             none_q;
  logic [IDX_W-1:0] min_idx_q;
  logic [KEY_W-1:0] min_key_q;

  logic             start_now;
  logic [KEY_W-1:0] cur_key;
  logic             cur_sel;
  logic             cur_lt_best;

  assign start_now = bus.i_start && ((state == IDLE) || (state == DONE));
  assign cur_key   = snap_keys[idx];
  assign cur_sel   = snap_mask[idx];

  key_lt_cmp #(
    .KEY_W (KEY_W)
  ) u_cmp (
    .a      (cur_key),
    .b      (best_key),
    .a_lt_b (cur_lt_best)
  );

  // Freeze the request set at launch so late changes cannot disturb a running scan
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < N_REQ; k++) begin
        snap_keys[k] <= '0;
      end
      snap_mask <= '0;
    end else if (start_now) begin
      for (int k = 0; k < N_REQ; k++) begin
        snap_keys[k] <= bus.i_keys[k*KEY_W +: KEY_W];
      end
      snap_mask <= bus.i_req_mask;
    end
  end

  // Scan controller with registered status and result outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      seeded    <= 1'b0;
      best_key  <= '0;
      best_idx  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      valid_q   <= 1'b0;
      none_q    <= 1'b0;
      min_idx_q <= '0;
      min_key_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.i_start) begin
            idx      <= '0;
            seeded   <= 1'b0;
            best_key <= '0;
            best_idx <= '0;
            busy_q   <= 1'b1;
            valid_q  <= 1'b0;
            none_q   <= 1'b0;
            state    <= SCAN;
          end
        end

        SCAN: begin
          if (bus.i_abort) begin
            busy_q <= 1'b0;
            state  <= IDLE;
          end else begin
            if (cur_sel && (!seeded || cur_lt_best)) begin
              best_key <= cur_key;
              best_idx <= idx;
              seeded   <= 1'b1;
            end
            if (idx == LAST_IDX) begin
              busy_q <= 1'b0;
              state  <= DONE;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end

        DONE: begin
          // The finished scan is always published with its done pulse, even when
          // a back-to-back start launches the next scan on this same edge
          done_q    <= 1'b1;
          min_idx_q <= best_idx;
          min_key_q <= best_key;
          valid_q   <= seeded;
          none_q    <= ~seeded;
          if (bus.i_start) begin
            idx      <= '0;
            seeded   <= 1'b0;
            best_key <= '0;
            best_idx <= '0;
            busy_q   <= 1'b1;
            state    <= SCAN;
          end else begin
            state <= IDLE;
          end
        end

        default: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.o_busy    = busy_q;
  assign bus.o_done    = done_q;
  assign bus.o_valid   = valid_q;
  assign bus.o_none    = none_q;
  assign bus.o_min_idx = min_idx_q;
  assign bus.o_min_key = min_key_q;

endmodule

// File: tb/tb_min_key_scheduler.sv
// Self-checking bench for min_key_scheduler: table vectors, corner sequences, random scans.
module tb_min_key_scheduler;
  import min_sched_pkg::*;

  localparam int N_REQ = 8;
  localparam int KEY_W = 6;

  logic i_clk = 1'b0;
  logic i_rst_n;

  always #5 i_clk = ~i_clk;

  min_key_scheduler_if #(.N_REQ(N_REQ), .KEY_W(KEY_W)) bus ();

  min_key_scheduler #(
    .N_REQ (N_REQ),
    .KEY_W (KEY_W)
  ) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [47:0] keys;
    logic [7:0]  mask;
    int          exp_idx;
    int          exp_key;
    int          exp_valid;
  } vec_t;

  task automatic check_output(input string name, input int actual, input int required);
    checks++;
    if (actual != required) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, required);
    end
  endtask

  function automatic logic [47:0] pk8(input int k0, input int k1, input int k2, input int k3,
                                      input int k4, input int k5, input int k6, input int k7);
    return {6'(k7), 6'(k6), 6'(k5), 6'(k4), 6'(k3), 6'(k2), 6'(k1), 6'(k0)};
  endfunction

  // Reference: smallest masked key value first, then the lowest index holding it
  function automatic void ref_min(input logic [47:0] keys, input logic [7:0] mask,
                                  output int idx, output int key, output int valid);
    int best;
    best  = 64;
    idx   = 0;
    key   = 0;
    valid = 0;
    for (int k = 0; k < N_REQ; k++) begin
      if (mask[k] && (int'(keys[k*KEY_W +: KEY_W]) < best)) best = int'(keys[k*KEY_W +: KEY_W]);
    end
    if (best < 64) begin
      valid = 1;
      key   = best;
      for (int k = N_REQ - 1; k >= 0; k--) begin
        if (mask[k] && (int'(keys[k*KEY_W +: KEY_W]) == best)) idx = k;
      end
    end
  endfunction

  // Launch one scan from IDLE, disturb the inputs mid-scan, watch 12 cycles
  task automatic apply_stimulus(input logic [47:0] keys, input logic [7:0] mask,
                                output int done_n, output int done_cnt, output int busy_cnt,
                                output int r_idx, output int r_key, output int r_valid,
                                output int r_none);
    @(negedge i_clk);
    bus.i_keys     = keys;
    bus.i_req_mask = mask;
    bus.i_start    = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    bus.i_start = 1'b0;
    done_n   = -1;
    done_cnt = 0;
    busy_cnt = 0;
    r_idx    = -1;
    r_key    = -1;
    r_valid  = -1;
    r_none   = -1;
    for (int n = 0; n < 12; n++) begin
      if (n > 0) @(negedge i_clk);
      if (bus.o_busy) busy_cnt++;
      if (bus.o_done) begin
        done_cnt++;
        if (done_n < 0) begin
          done_n  = n;
          r_idx   = int'(bus.o_min_idx);
          r_key   = int'(bus.o_min_key);
          r_valid = int'(bus.o_valid);
          r_none  = int'(bus.o_none);
        end
      end
      if (n == 3) begin
        bus.i_keys     = ~keys;
        bus.i_req_mask = 8'($urandom);
      end
    end
  endtask

  task automatic check_scan(input string tag, input logic [47:0] keys, input logic [7:0] mask,
                            input int exp_idx, input int exp_key, input int exp_valid);
    int done_n, done_cnt, busy_cnt, r_idx, r_key, r_valid, r_none;
    apply_stimulus(keys, mask, done_n, done_cnt, busy_cnt, r_idx, r_key, r_valid, r_none);
    check_output({tag, "_latency"}, done_n, N_REQ + 1);
    check_output({tag, "_done_pulses"}, done_cnt, 1);
    check_output({tag, "_busy_cycles"}, busy_cnt, N_REQ);
    check_output({tag, "_idx"}, r_idx, exp_idx);
    check_output({tag, "_key"}, r_key, exp_key);
    check_output({tag, "_valid"}, r_valid, exp_valid);
    check_output({tag, "_none"}, r_none, 1 - exp_valid);
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, "_busy"}, int'(bus.o_busy), 0);
    check_output({tag, "_done"}, int'(bus.o_done), 0);
    check_output({tag, "_valid"}, int'(bus.o_valid), 0);
    check_output({tag, "_none"}, int'(bus.o_none), 0);
    check_output({tag, "_idx"}, int'(bus.o_min_idx), 0);
    check_output({tag, "_key"}, int'(bus.o_min_key), 0);
  endtask

  initial begin
    vec_t        vecs[6];
    logic [47:0] base_keys;
    logic [47:0] all63;
    logic [47:0] rk;
    logic [7:0]  rm;
    int          e_idx, e_key, e_valid;
    int          cnt, first_n, second_n, idx1, key1, idx2, key2;

    base_keys = pk8(20, 7, 33, 7, 63, 12, 9, 40);
    all63     = pk8(63, 63, 63, 63, 63, 63, 63, 63);

    vecs[0] = '{base_keys, 8'hFF, 1, 7, 1};
    vecs[1] = '{base_keys, 8'b1111_0101, 6, 9, 1};
    vecs[2] = '{base_keys, 8'h00, 0, 0, 0};
    vecs[3] = '{all63, 8'hFF, 0, 63, 1};
    vecs[4] = '{pk8(1, 1, 1, 1, 1, 1, 1, 0), 8'hFF, 7, 0, 1};
    vecs[5] = '{base_keys, 8'h80, 7, 40, 1};

    i_rst_n        = 1'b0;
    bus.i_start    = 1'b0;
    bus.i_abort    = 1'b0;
    bus.i_keys     = '0;
    bus.i_req_mask = '0;
    #12;
    check_all_zero("reset");
    @(negedge i_clk);
    i_rst_n = 1'b1;

    for (int v = 0; v < 6; v++) begin
      check_scan($sformatf("vec%0d", v), vecs[v].keys, vecs[v].mask,
                 vecs[v].exp_idx, vecs[v].exp_key, vecs[v].exp_valid);
    end

    // Abort on the 4th scan cycle: no done, prior result held, valid stays cleared
    check_scan("pre_abort", base_keys, 8'hFF, 1, 7, 1);
    @(negedge i_clk);
    bus.i_keys     = pk8(2, 2, 2, 2, 2, 2, 2, 2);
    bus.i_req_mask = 8'hFF;
    bus.i_start    = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    bus.i_start = 1'b0;
    repeat (3) @(negedge i_clk);
    bus.i_abort = 1'b1;
    @(negedge i_clk);
    bus.i_abort = 1'b0;
    check_output("abort_busy", int'(bus.o_busy), 0);
    cnt = 0;
    repeat (12) begin
      @(negedge i_clk);
      if (bus.o_done) cnt++;
    end
    check_output("abort_no_done", cnt, 0);
    check_output("abort_valid", int'(bus.o_valid), 0);
    check_output("abort_none", int'(bus.o_none), 0);
    check_output("abort_idx", int'(bus.o_min_idx), 1);
    check_output("abort_key", int'(bus.o_min_key), 7);

    // Back-to-back: start held high, second scan launched from DONE with new keys
    @(negedge i_clk);
    bus.i_keys     = base_keys;
    bus.i_req_mask = 8'hFF;
    bus.i_start    = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    first_n  = -1;
    second_n = -1;
    cnt      = 0;
    idx1 = -1; key1 = -1; idx2 = -1; key2 = -1;
    for (int n = 0; n < 25; n++) begin
      if (n > 0) @(negedge i_clk);
      if (bus.o_done) begin
        cnt++;
        if (first_n < 0) begin
          first_n = n;
          idx1 = int'(bus.o_min_idx);
          key1 = int'(bus.o_min_key);
        end else if (second_n < 0) begin
          second_n = n;
          idx2 = int'(bus.o_min_idx);
          key2 = int'(bus.o_min_key);
        end
      end
      if (n == 8) bus.i_keys = all63;
      if (n == 9) bus.i_start = 1'b0;
    end
    check_output("b2b_first_latency", first_n, N_REQ + 1);
    check_output("b2b_spacing", second_n - first_n, N_REQ + 1);
    check_output("b2b_pulses", cnt, 2);
    check_output("b2b_idx1", idx1, 1);
    check_output("b2b_key1", key1, 7);
    check_output("b2b_idx2", idx2, 0);
    check_output("b2b_key2", key2, 63);

    // Asynchronous reset in the middle of a scan
    @(negedge i_clk);
    bus.i_keys     = base_keys;
    bus.i_req_mask = 8'hFF;
    bus.i_start    = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    bus.i_start = 1'b0;
    repeat (2) @(negedge i_clk);
    check_output("pre_rst_busy", int'(bus.o_busy), 1);
    #2;
    i_rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    cnt = 0;
    repeat (12) begin
      @(negedge i_clk);
      if (bus.o_done) cnt++;
    end
    check_output("async_rst_no_done", cnt, 0);
    i_rst_n = 1'b1;

    // Randomized scans against the reference model
    for (int t = 0; t < 25; t++) begin
      for (int k = 0; k < N_REQ; k++) begin
        rk[k*KEY_W +: KEY_W] = 6'($urandom_range(0, (t % 2 == 1) ? 7 : 63));
      end
      rm = 8'($urandom);
      if (t == 0) rm = 8'h00;
      ref_min(rk, rm, e_idx, e_key, e_valid);
      check_scan($sformatf("rand%0d", t), rk, rm, e_idx, e_key, e_valid);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
